// File: rtl/input_cond_pkg.sv
// input_cond_pkg
//   Shared types and helpers for the input conditioner:
//   - start_state_t : start-button FSM states
//   - cnt_w()       : counter width for a modulus-n counter (at least 1 bit)
//   - inactive levels the synchronisers load on reset
package input_cond_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_HELD  = 2'd2
  } start_state_t;

  // Width that holds values 0..n-1.
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Raw level of a released start button, given its polarity.
  function automatic logic start_released(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

  localparam logic CHAVE_INACTIVE = 1'b0;

endpackage

// File: rtl/input_conditioner_debounce.sv
// debounce_cell
//   Synchroniser chain followed by a stability filter for one async bit.
//   A new level is accepted after DEBOUNCE_CYCLES consecutive cycles of
//   disagreement with the current stable level; any agreement clears the run.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   raw         - asynchronous input
//   stable      - debounced level (internal polarity, 1 = active)
//   stable_next - value stable takes at the next edge (lets consumers
//                 register events coincident with the stable change)
module debounce_cell
  import input_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic SYNC_INIT       = 1'b0,
  parameter logic INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic stable_next
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{SYNC_INIT}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Polarity is fixed after the last flop so the chain sees the raw pin only.
  assign synced = sync_q[SYNC_STAGES-1] ^ INVERT;

  // Acceptance clears the counter, so it never needs to wrap.
  always_comb begin
    stable_next = stable;
    cnt_next    = '0;
    if (synced != stable) begin
      if (cnt == CNT_LAST) stable_next = synced;
      else                 cnt_next    = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      stable <= stable_next;
      cnt    <= cnt_next;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
//   Synchronises and debounces the start button and the four chave switches
//   feeding the Nios PIO inputs. Everything is in the clk_clk domain.
// Ports:
//   clk_clk       - system clock
//   reset_reset   - synchronous active-high reset
//   start_raw     - async push-button (polarity set by START_ACTIVE_LOW)
//   chave_raw     - async slide switches
//   start_level   - debounced press state, 1 = pressed
//   start_pulse   - one-cycle strobe per accepted press
//   chave_stable  - debounced switches
//   chave_changed - one-cycle strobe when any chave_stable bit changes
//   ready         - high once the initial debounce window has elapsed
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int START_ACTIVE_LOW = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       start_raw,
  input  logic [3:0] chave_raw,
  output logic       start_level,
  output logic       start_pulse,
  output logic [3:0] chave_stable,
  output logic       chave_changed,
  output logic       ready
);

  localparam int            RW       = cnt_w(SYNC_STAGES + DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] RDY_LAST = RW'(SYNC_STAGES + DEBOUNCE_CYCLES - 1);

  logic         press_next;
  logic [3:0]   chave_next;
  logic [RW-1:0] rdy_cnt;
  logic         ready_next;
  start_state_t state, state_next;

  // ---- debounce cells -------------------------------------------------
  debounce_cell #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_INIT      (start_released(START_ACTIVE_LOW)),
    .INVERT         (START_ACTIVE_LOW != 0)
  ) u_start (
    .clk        (clk_clk),
    .rst        (reset_reset),
    .raw        (start_raw),
    .stable     (start_level),
    .stable_next(press_next)
  );

  for (genvar i = 0; i < 4; i++) begin : g_chave
    debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_INIT      (CHAVE_INACTIVE),
      .INVERT         (1'b0)
    ) u_cell (
      .clk        (clk_clk),
      .rst        (reset_reset),
      .raw        (chave_raw[i]),
      .stable     (chave_stable[i]),
      .stable_next(chave_next[i])
    );
  end

  // ---- ready: first debounce window after reset -----------------------
  assign ready_next = ready | (rdy_cnt == RDY_LAST);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rdy_cnt <= '0;
      ready   <= 1'b0;
    end else if (!ready) begin
      rdy_cnt <= rdy_cnt + RW'(1);
      ready   <= ready_next;
    end
  end

  // ---- start FSM ------------------------------------------------------
  // Driven by next-cycle values so S_PRESS lines up with the start_level
  // rise. S_HELD is only left once ready: a button held through reset is
  // accepted on the same edge ready rises and must not count as a press.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= S_HELD;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (press_next && ready_next)  state_next = S_PRESS;
      S_PRESS:                                state_next = S_HELD;
      S_HELD:  if (!press_next && ready_next) state_next = S_IDLE;
      default:                                state_next = S_HELD;
    endcase
  end

  assign start_pulse = (state == S_PRESS);

  // ---- switch change strobe -------------------------------------------
  // Gated by the registered ready so power-up positions, accepted on the
  // edge ready rises, do not strobe.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) chave_changed <= 1'b0;
    else             chave_changed <= ready && (chave_next != chave_stable);
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Directed scenarios followed by random hold/bounce stimulus. A reference
//   model built on a "last D synchronised samples all disagree" window rule
//   pushes the expected outputs for every clock edge into a queue; a monitor
//   on the falling edge pops and compares them against the DUT.
module tb_input_conditioner;

  localparam int S = 2;
  localparam int D = 8;

  typedef struct {
    logic       level;
    logic       pulse;
    logic [3:0] stable;
    logic       changed;
    logic       ready;
  } exp_t;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic       start_raw;
  logic [3:0] chave_raw;
  logic       start_level, start_pulse, chave_changed, ready;
  logic [3:0] chave_stable;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  input_conditioner #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .START_ACTIVE_LOW(1)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .start_raw    (start_raw),
    .chave_raw    (chave_raw),
    .start_level  (start_level),
    .start_pulse  (start_pulse),
    .chave_stable (chave_stable),
    .chave_changed(chave_changed),
    .ready        (ready)
  );

  always #5 clk_clk = ~clk_clk;

  // ---- reference model ------------------------------------------------
  // Bit 0 = start (1 = pressed), bits 1..4 = chave.
  int         m_k;
  bit [S-1:0] m_dl  [5];
  bit         m_win [5][$];
  bit [4:0]   m_st;
  bit         m_rdy, m_armed;

  always @(posedge clk_clk) begin
    exp_t     e;
    bit [4:0] smp, old;
    bit       x, all_diff, prev_rdy, pulse;
    smp = {chave_raw, ~start_raw};
    if (reset_reset) begin
      m_k = 0;
      for (int b = 0; b < 5; b++) begin
        m_dl[b] = '0;           // synchronisers hold the inactive level
        m_win[b].delete();
      end
      m_st = '0; m_rdy = 0; m_armed = 0;
      e = '{level: 0, pulse: 0, stable: 4'h0, changed: 0, ready: 0};
    end else begin
      m_k++;
      old = m_st;
      prev_rdy = m_rdy;
      for (int b = 0; b < 5; b++) begin
        x = m_dl[b][S-1];
        m_dl[b] = {m_dl[b][S-2:0], smp[b]};
        m_win[b].push_back(x);
        if (m_win[b].size() > D) void'(m_win[b].pop_front());
        if (m_win[b].size() == D) begin
          all_diff = 1;
          foreach (m_win[b][j]) if (m_win[b][j] == m_st[b]) all_diff = 0;
          if (all_diff) m_st[b] = ~m_st[b];
        end
      end
      m_rdy = (m_k >= S + D);
      // Armed once the button is seen released while ready; a press
      // accepted while armed produces exactly one pulse.
      pulse = 0;
      if (m_st[0]) begin
        pulse = m_armed;
        m_armed = 0;
      end else if (m_rdy) begin
        m_armed = 1;
      end
      e.level   = m_st[0];
      e.pulse   = pulse;
      e.stable  = m_st[4:1];
      e.changed = prev_rdy && (m_st[4:1] != old[4:1]);
      e.ready   = m_rdy;
    end
    exp_q.push_back(e);
  end

  // ---- monitor ----------------------------------------------------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  always @(negedge clk_clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("start_level",   {3'b0, start_level},   {3'b0, e.level});
      check("start_pulse",   {3'b0, start_pulse},   {3'b0, e.pulse});
      check("chave_stable",  chave_stable,          e.stable);
      check("chave_changed", {3'b0, chave_changed}, {3'b0, e.changed});
      check("ready",         {3'b0, ready},         {3'b0, e.ready});
    end
  end

  // ---- stimulus -----------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  initial begin
    int hold;
    reset_reset = 1'b1;
    start_raw   = 1'b1;
    chave_raw   = 4'h0;
    step(3);
    // power-up, idle inputs
    reset_reset = 1'b0;
    step(30);
    // clean press and release
    start_raw = 1'b0; step(20);
    start_raw = 1'b1; step(20);
    // bouncing press
    for (int i = 0; i < 2; i++) begin
      start_raw = 1'b0; step(3);
      start_raw = 1'b1; step(3);
    end
    start_raw = 1'b0; step(20);
    start_raw = 1'b1; step(20);
    // button held through reset, then release and re-press
    start_raw = 1'b0;
    reset_reset = 1'b1; step(3);
    reset_reset = 1'b0; step(30);
    start_raw = 1'b1; step(20);
    start_raw = 1'b0; step(20);
    start_raw = 1'b1; step(20);
    // switch change and a short glitch on bit 3
    chave_raw = 4'h5; step(20);
    chave_raw = 4'hD; step(5);
    chave_raw = 4'h5; step(20);
    // consecutive-cycle changes plus a press accepted on the same edge
    chave_raw = 4'h4; start_raw = 1'b0; step(1);
    chave_raw = 4'h6; step(20);
    start_raw = 1'b1; step(15);
    // switches set through reset, then reset mid-debounce
    chave_raw = 4'hF;
    reset_reset = 1'b1; step(3);
    reset_reset = 1'b0; step(20);
    chave_raw = 4'h0; step(5);
    reset_reset = 1'b1; step(2);
    reset_reset = 1'b0; step(25);
    // random holds and bounces
    for (int seg = 0; seg < 70; seg++) begin
      if ($urandom_range(0, 14) == 0) begin
        reset_reset = 1'b1;
        step($urandom_range(1, 2));
        reset_reset = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) start_raw = ~start_raw;
      if ($urandom_range(0, 1) == 0) chave_raw = 4'($urandom);
      hold = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 16);
      step(hold);
    end
    step(25);
    @(negedge clk_clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Conditions the raw board inputs before they reach the Nios PIO inputs: start button to start_external_connection_export, and the four switches to chave_external_connection_export.
- Each raw input is synchronised, then debounced.
- The start press is turned into a clean level plus a single-cycle pulse.
- A switch-change strobe is also produced.
- Sits directly upstream of the nios system; all outputs are in the clk_clk domain.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each synchroniser chain (minimum 2).
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz; minimum 2).
START_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (DE-board keys).

Ports:
clk_clk  in  1  system clock, same clock as the nios system.
reset_reset  in  1  synchronous, active-high reset.
start_raw  in  1  asynchronous push-button.
chave_raw  in  4  asynchronous slide switches.
start_level  out  1  debounced press state, 1 = pressed; drives start_external_connection_export.
start_pulse  out  1  one-cycle strobe per accepted press.
chave_stable  out  4  debounced switches; drives chave_external_connection_export.
chave_changed  out  1  one-cycle strobe when any chave_stable bit changes.
ready  out  1  high once the initial debounce window has elapsed.

Behaviour:
Clock, reset and reset values:
- Single clock, clk_clk.
- reset_reset is synchronous and active-high; it is sampled only on the rising edge of clk_clk.
- Reset values:
  - start_level=0, start_pulse=0, chave_stable=4'h0, chave_changed=0, ready=0.
  - Synchroniser chains load the "inactive" level: released for start, 0 for the switches.
  - All counters load 0.
  - Start FSM loads S_HELD.

Synchroniser:
- Each input passes through SYNC_STAGES flops.
- For START_ACTIVE_LOW=1, start is inverted after synchronisation, so internally 1 = pressed.

Debounce cell (one per bit, 5 in total):
- Holds a stable register and a counter of width clog2(DEBOUNCE_CYCLES).
- synced == stable: counter clears to 0.
- synced != stable: counter increments.
- Counter == DEBOUNCE_CYCLES-1 while the levels still differ: stable <= synced and counter <= 0 in the same cycle.
- A glitch shorter than DEBOUNCE_CYCLES clears the counter and is never propagated.
- Latency from a raw edge to a stable change: SYNC_STAGES + DEBOUNCE_CYCLES cycles, exactly.
- The counter saturates logically (it cannot wrap) because acceptance resets it.

Ready counter:
- Counts from reset release; ready goes 1 after SYNC_STAGES + DEBOUNCE_CYCLES cycles and stays 1 until the next reset.

Start FSM (states S_IDLE, S_PRESS, S_HELD):
- S_IDLE: debounced press=1 and ready=1 -> S_PRESS.
- S_PRESS: lasts exactly one cycle with start_pulse=1; then -> S_HELD.
- S_HELD: debounced press=0 -> S_IDLE.
- Resetting into S_HELD means a button held through reset produces no pulse until it has been released and pressed again.
- start_level follows the debounced value directly, independent of the FSM.

chave_changed:
- Registered: 1 for one cycle after any chave_stable bit changes.
- Suppressed while ready=0, so power-up switch positions do not strobe.
- Several bits changing in the same cycle, or in consecutive cycles, each produce their own strobe cycle (no merging beyond the same cycle).

Simultaneous events and reset mid-operation:
- Start and switch acceptances in the same cycle are independent.
- Reset asserted mid-debounce discards the partial count.
- Reset asserted during S_PRESS drops the pulse in the next cycle.

Decomposition:
- Package input_cond_pkg holds:
  - start FSM state enum {S_IDLE, S_PRESS, S_HELD};
  - a clog2-based width function for the counters;
  - the inactive-level constants.
- One sub-module, debounce_cell (parameters SYNC_STAGES, DEBOUNCE_CYCLES), instantiated once for start and four times for chave via a generate loop.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
1. Release reset, raw inputs idle -> ready rises exactly 10 cycles later; all other outputs stay 0; no chave_changed.
2. start_raw 1->0 held for 20 cycles -> start_level=1 exactly 10 cycles after the edge; start_pulse high for exactly 1 cycle, coincident with the start_level rise; release -> start_level=0 after 10 cycles; no second pulse.
3. start_raw bounce pattern 0,1,0,1 of 3 cycles each, then 0 held -> only one start_pulse, 10 cycles after the final falling edge.
4. Button held low through reset and 30 cycles beyond -> start_level=1 but no start_pulse; release and re-press -> exactly one pulse.
5. chave_raw 0000->0101 after ready -> chave_stable=4'h5 after 10 cycles; chave_changed high for 1 cycle; a 5-cycle glitch on bit 3 -> no change.
6. Switches at 4'hF during reset -> chave_stable=4'hF after 10 cycles, chave_changed stays 0; assert reset mid-debounce of a later change -> outputs return to reset values on the next edge.
